pe_demux_gather: RTL
====================

// Module: pe_demux_gather
// PURPOSE
//  Inverse of the PE lane mux: gathers a serial stream of WIDTH-bit words into a
//  DEPTH-lane register bank (data_out[0:DEPTH-1]) and presents it as one vector.
//  Sits between the serial activation/weight feed and the PE array lane inputs.
//  Lanes fill sequentially (pointer) or by explicit lane select (addressed mode).
//  Valid/ready on both sides.
// PARAMETERS
//  WIDTH      8               data width per lane
//  DEPTH      8               number of lanes (need not be a power of 2)
//  SEL_WIDTH  $clog2(DEPTH)   lane select / pointer width
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  clear      in   1          synchronous flush to reset state
//  in_valid   in   1          input word valid
//  in_ready   out  1          block can accept a word
//  in_data    in   WIDTH      input word
//  in_sel_en  in   1          1: write lane in_sel; 0: write lane wr_ptr
//  in_sel     in   SEL_WIDTH  explicit lane index (addressed mode)
//  in_last    in   1          word closes the vector early
//  out_valid  out  1          gathered vector available
//  out_ready  in   1          consumer takes vector
//  data_out   out  WIDTH x DEPTH  lane registers
//  out_mask   out  DEPTH      bit i = lane i written since last drain
//  wr_ptr     out  SEL_WIDTH  next sequential lane
//  err_oob    out  1          sticky: addressed write with in_sel >= DEPTH
// BEHAVIOUR
//  Reset (rst=1, async): state FILL, data_out all 0, out_mask 0, wr_ptr 0,
//   out_valid 0, err_oob 0. in_ready is 1 out of reset.
//  Accept = in_valid && in_ready. States FILL and HOLD.
//  FILL: in_ready=1, out_valid=0. On accept, lane L = in_sel_en ? in_sel : wr_ptr:
//   data_out[L] <= in_data, out_mask[L] <= 1 (rewrite overwrites, mask unchanged).
//   Sequential write: wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
//   Addressed write: wr_ptr <= (in_sel==DEPTH-1) ? 0 : in_sel+1.
//   Addressed in_sel >= DEPTH: word consumed, no lane/mask/ptr change, err_oob <= 1.
//   Go HOLD after accept if next out_mask is all ones, or in_last=1 (even if the
//   write was dropped as OOB).
//  HOLD: in_ready=0, out_valid=1; data_out/out_mask held stable while !out_ready.
//   out_valid && out_ready: go FILL, data_out <= 0, out_mask <= 0, wr_ptr <= 0.
//   Unwritten lanes therefore always read 0.
//  Latency: out_valid rises the cycle after the completing word is accepted;
//   in_ready rises the cycle after the drain handshake. Max 1 vector per DEPTH+1 cycles.
//  No in->out combinational path; in_ready depends on state only.
//  clear=1: same effect as reset at next edge. Overrides any simultaneous accept
//   or drain; that word/vector is dropped.
//  err_oob cleared only by rst or clear.
//  rst mid-vector: partial data discarded; no out_valid for the partial vector.
// TESTING
//  1 Seq fill, DEPTH=8: words 1..8 back-to-back -> out_valid next cycle,
//    data_out={1..8}, mask=8'hFF, in_ready=0.
//  2 Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_valid
//    ignored; out_ready=1 -> data/mask 0, wr_ptr=0, in_ready=1 next cycle.
//  3 Early close: 3 words, third with in_last=1 -> mask=8'h07, lanes 3..7 = 0.
//  4 Addressed: sel 5 (0xAA), then sequential 0xBB -> lane 6=0xBB, wr_ptr=7;
//    sel 5 again (0xCC) overwrites, mask bit 5 unchanged.
//  5 DEPTH=6, sel=7 -> err_oob=1, no lane change. clear -> all reset values, err_oob=0.
//  6 Assert clear in the drain-handshake cycle, and rst after 4 words ->
//    reset values, no out_valid.

Source files
------------

// File: rtl/pe_demux_gather.sv
// Serial-to-parallel lane gatherer: fills a DEPTH-lane bank from a word stream
// and hands the whole vector to the PE array with valid/ready on both sides.
module pe_demux_gather #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel_en,
    input  logic [SEL_WIDTH-1:0]   in_sel,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DEPTH*WIDTH-1:0] data_out,
    output logic [DEPTH-1:0]       out_mask,
    output logic [SEL_WIDTH-1:0]   wr_ptr,
    output logic                   err_oob
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_LANE = SEL_WIDTH'(DEPTH - 1);

    state_t                 state, state_nxt;
    logic [DEPTH*WIDTH-1:0] data_nxt;
    logic [DEPTH-1:0]       mask_nxt;
    logic [SEL_WIDTH-1:0]   ptr_nxt;
    logic                   err_nxt;
    logic [SEL_WIDTH-1:0]   lane;
    logic                   oob;
    logic                   accept;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign lane      = in_sel_en ? in_sel : wr_ptr;
    // Only reachable when DEPTH is not a power of two.
    assign oob       = in_sel_en && (32'(in_sel) >= DEPTH);

    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        mask_nxt  = out_mask;
        ptr_nxt   = wr_ptr;
        err_nxt   = err_oob;
        unique case (state)
            FILL: begin
                if (accept) begin
                    if (oob) begin
                        err_nxt = 1'b1;
                    end else begin
                        data_nxt[lane*WIDTH +: WIDTH] = in_data;
                        mask_nxt[lane] = 1'b1;
                        ptr_nxt = (lane == LAST_LANE) ? '0 : lane + 1'b1;
                    end
                    if ((&mask_nxt) || in_last)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = FILL;
                    data_nxt  = '0;
                    mask_nxt  = '0;
                    ptr_nxt   = '0;
                end
            end
        endcase
        // Flush wins over any accept or drain in the same cycle.
        if (clear) begin
            state_nxt = FILL;
            data_nxt  = '0;
            mask_nxt  = '0;
            ptr_nxt   = '0;
            err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            data_out <= '0;
            out_mask <= '0;
            wr_ptr   <= '0;
            err_oob  <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_out <= data_nxt;
            out_mask <= mask_nxt;
            wr_ptr   <= ptr_nxt;
            err_oob  <= err_nxt;
        end
    end

endmodule
